// File: rtl/adder_serial_pkg.sv
// Types and helpers shared by the serial adder and its chunk datapath.
`include "adder_defs.vh"

package adder_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `ADDER_ST_IDLE,
    ST_BUSY = `ADDER_ST_BUSY,
    ST_DONE = `ADDER_ST_DONE
  } adder_state_e;

  // Counter width that stays legal (>= 1 bit) even when a single chunk spans the word.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/adder_bit.sv
// Single-bit full adder, the basic cell of the chunk datapath.
module adder_bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple adder built as a generate chain of adder_bit cells.
`include "adder_defs.vh"

module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  `ADDER_CHECK_PARAMS(CHUNK, CHUNK)

  logic [CHUNK:0] carry_chain;

  assign carry_chain[0] = carry_in;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    adder_bit u_bit (
      .a         (a[gi]),
      .b         (b[gi]),
      .carry_in  (carry_chain[gi]),
      .sum       (sum[gi]),
      .carry_out (carry_chain[gi+1])
    );
  end

  assign carry_out = carry_chain[CHUNK];

endmodule

// File: rtl/adder_defs.vh
// Shared state encodings and the WIDTH/CHUNK legality check for the serial adder family.
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH

`define ADDER_ST_IDLE 2'd0
`define ADDER_ST_BUSY 2'd1
`define ADDER_ST_DONE 2'd2

// Expands to an elaboration-time generate check; place at module scope.
`define ADDER_CHECK_PARAMS(W, C) \
  if ((W) < 1 || (C) < 1 || (C) > (W) || ((W) % (C)) != 0) begin : g_param_err \
    $error("adder: illegal WIDTH=%0d / CHUNK=%0d", (W), (C)); \
  end

`endif

// File: rtl/adder_serial.sv
// Multi-cycle a+b+carry_in, CHUNK bits per clock, LSB first, valid/ready on both sides.
// Define ADDER_SERIAL_OVERFLOW_EN to add the signed-overflow output.
`include "adder_defs.vh"

module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ADDER_SERIAL_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  `ADDER_CHECK_PARAMS(WIDTH, CHUNK)

  adder_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] acc_shift;

`ifdef ADDER_SERIAL_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a         (a_q[CHUNK-1:0]),
    .b         (b_q[CHUNK-1:0]),
    .carry_in  (carry_q),
    .sum       (chunk_sum),
    .carry_out (chunk_cout)
  );

  // New chunk enters at the top; after NCHUNK shifts the LSB chunk sits at bit 0.
  assign acc_shift = (acc_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = carry_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
`ifdef ADDER_SERIAL_OVERFLOW_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_shift;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          sum_d       = acc_shift;
          cout_d      = chunk_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef ADDER_SERIAL_OVERFLOW_EN
          ovf_d       = (a_msb_q == b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ADDER_SERIAL_OVERFLOW_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADDER_SERIAL_OVERFLOW_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef ADDER_SERIAL_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_serial.sv
// Self-checking bench: directed + random ops on an 8/2 instance, exhaustive 4-bit sweep for CHUNK 1/2/4.
module tb_adder_serial;

  localparam int NCH8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- main 8-bit / 2-bit-chunk instance ----------------
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       op_cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       carry_out;
`ifdef ADDER_SERIAL_OVERFLOW_EN
  logic       overflow;
`endif

  adder_serial #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .carry_in  (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef ADDER_SERIAL_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, input int hold);
    logic [8:0] exp;
    logic       exp_ovf;
    int         k;
    exp     = 9'(ta) + 9'(tbv) + 9'(tc);
    exp_ovf = (ta[7] == tbv[7]) && (exp[7] != ta[7]);
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1; op_a = ta; op_b = tbv; op_cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); op_cin = 1'($urandom);
    check("busy_ready", in_ready, 0);
    check("busy_valid", out_valid, 0);
    for (int i = 1; i <= NCH8; i++) begin
      @(posedge clk); #1;
      check($sformatf("lat_valid_%0d", i), out_valid, (i == NCH8) ? 1 : 0);
      check($sformatf("lat_ready_%0d", i), in_ready, 0);
    end
    check("result", {carry_out, sum}, exp);
`ifdef ADDER_SERIAL_OVERFLOW_EN
    check("overflow", overflow, exp_ovf);
`endif
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_result", {carry_out, sum}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
    check("idle_retain", {carry_out, sum}, exp);
    $display("[TB] txn a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d hold=%0d",
             ta, tbv, tc, exp[7:0], exp[8], exp_ovf, hold);
  endtask

  // ---------------- exhaustive 4-bit sweeps ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int C  = 1 << gi;
    localparam int NC = 4 / C;
    logic       s_rst = 1'b1;
    logic       s_iv = 1'b0;
    logic       s_ir;
    logic [3:0] s_a = '0;
    logic [3:0] s_b = '0;
    logic       s_cin = 1'b0;
    logic       s_ov;
    logic       s_or = 1'b0;
    logic [3:0] s_sum;
    logic       s_cout;
    logic       sw_done = 1'b0;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    logic       s_ovf;
`endif

    adder_serial #(.WIDTH(4), .CHUNK(C)) u_sw (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .a         (s_a),
      .b         (s_b),
      .carry_in  (s_cin),
      .out_valid (s_ov),
      .out_ready (s_or),
      .sum       (s_sum),
      .carry_out (s_cout)
`ifdef ADDER_SERIAL_OVERFLOW_EN
      ,
      .overflow  (s_ovf)
`endif
    );

    initial begin
      logic [4:0] exp;
      int         k;
      logic       go;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int v = 0; v < 512; v++) begin
        s_a   = v[3:0];
        s_b   = v[7:4];
        s_cin = v[8];
        exp   = 5'(s_a) + 5'(s_b) + 5'(s_cin);
        k = 0;
        while (!s_ir && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        check($sformatf("sw_c%0d_ready", C), s_ir, 1);
        s_iv = 1'b1;
        @(posedge clk); #1;
        s_iv = 1'b0;
        k = 0;
        while (!s_ov && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        check($sformatf("sw_c%0d_latency", C), k, NC);
        check($sformatf("sw_c%0d_result", C), {s_cout, s_sum}, exp);
        go = 1'b0;
        k  = 0;
        while (!go) begin
          s_or = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          go = s_or;
          k++;
          if (!go) check($sformatf("sw_c%0d_held", C), {s_ov, s_cout, s_sum}, {1'b1, exp});
        end
        s_or = 1'b0;
        check($sformatf("sw_c%0d_release", C), {s_ov, s_ir}, 2'b01);
        $display("[TB] sweep chunk=%0d a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d",
                 C, s_a, s_b, s_cin, exp[3:0], exp[4]);
      end
      sw_done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    logic all_done;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h12, 8'h34, 1'b1, 5);
    run_op(8'h7F, 8'h01, 1'b0, 1);
    run_op(8'h80, 8'h80, 1'b0, 2);
    run_op(8'h10, 8'h20, 1'b0, 0);

    // Reset two edges into a BUSY operation.
    check("mid_ready", in_ready, 1);
    in_valid = 1'b1; op_a = 8'hC3; op_b = 8'h99; op_cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sum", sum, 0);
    check("midrst_cout", carry_out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
`ifdef ADDER_SERIAL_OVERFLOW_EN
    check("midrst_ovf", overflow, 0);
`endif
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_quiet", out_valid, 0);
    end
    run_op(8'h01, 8'h01, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    k = 0;
    all_done = g_sw[0].sw_done && g_sw[1].sw_done && g_sw[2].sw_done;
    while (!all_done && k < 30000) begin
      @(posedge clk); #1;
      k++;
      all_done = g_sw[0].sw_done && g_sw[1].sw_done && g_sw[2].sw_done;
    end
    check("sweep_complete", all_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
